// File: rtl/fp_acc_seq_pkg.sv
// Shared IEEE-754 constants: class flag, exception and rounding-attribute bit indices.
// Used by the accumulator, the fp_add datapath, the handshake interface and the testbench.
package fp_acc_seq_pkg;

  localparam int NTYPES      = 6;
  localparam int NEXCEPTIONS = 5;
  localparam int NRAS        = 4;

  // Class flags of a result (exactly one set for any encoding)
  localparam int FLAG_SNAN      = 0;
  localparam int FLAG_QNAN      = 1;
  localparam int FLAG_INFINITY  = 2;
  localparam int FLAG_ZERO      = 3;
  localparam int FLAG_SUBNORMAL = 4;
  localparam int FLAG_NORMAL    = 5;

  localparam int EXC_INVALID   = 0;
  localparam int EXC_DIVZERO   = 1;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 3;
  localparam int EXC_INEXACT   = 4;

  // One-hot rounding attribute positions
  localparam int RA_RNE = 0;
  localparam int RA_RTZ = 1;
  localparam int RA_RUP = 2;
  localparam int RA_RDN = 3;
  localparam int RA_RNA = 4;

  function automatic logic [NRAS:0] ra_sel(input int idx);
    logic [NRAS:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_acc_seq_if.sv
// Term/result handshake bundle for fp_acc_seq; the producer/consumer side uses
// the master modport, the accumulator the slave modport.
interface fp_acc_seq_if #(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int CNTW = 8
);
  import fp_acc_seq_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [NEXP+NSIG:0]     in_data;
  logic                   in_last;
  logic [NRAS:0]          ra;
  logic                   out_valid;
  logic                   out_ready;
  logic [NEXP+NSIG:0]     out_sum;
  logic [NTYPES-1:0]      out_flags;
  logic [NEXCEPTIONS-1:0] out_exception;
  logic [CNTW-1:0]        out_count;

  modport master (
    output in_valid, in_data, in_last, ra, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_exception, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, ra, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_exception, out_count
  );

endinterface

// File: rtl/fp_add.sv
// Combinational IEEE-754 adder with one-hot rounding attribute and exception flags.
// An all-zero or unrecognised attribute rounds to nearest-even.
module fp_add
  import fp_acc_seq_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  input  logic [NRAS:0]          ra,
  output logic [NEXP+NSIG:0]     sum,
  output logic [NEXCEPTIONS-1:0] exc
);

  localparam int W  = NSIG + 4;   // hidden + fraction + guard/round/sticky
  localparam int EW = NEXP + 2;
  localparam int MW = NSIG + 2;
  localparam logic [NEXP-1:0] EMAX = '1;
  localparam logic [NEXP-1:0] EBIG = EMAX - 1'b1;

  logic            sa, sb;
  logic [NEXP-1:0] ea, eb;
  logic [NSIG-1:0] fa, fb;
  logic            nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
  logic            rtz, rup, rdn, rna, rne;

  assign sa = a[NEXP+NSIG];
  assign sb = b[NEXP+NSIG];
  assign ea = a[NEXP+NSIG-1:NSIG];
  assign eb = b[NEXP+NSIG-1:NSIG];
  assign fa = a[NSIG-1:0];
  assign fb = b[NSIG-1:0];

  assign nan_a  = (ea == EMAX) && (fa != '0);
  assign nan_b  = (eb == EMAX) && (fb != '0);
  assign snan_a = nan_a && !fa[NSIG-1];
  assign snan_b = nan_b && !fb[NSIG-1];
  assign inf_a  = (ea == EMAX) && (fa == '0);
  assign inf_b  = (eb == EMAX) && (fb == '0);

  assign rtz = ra[RA_RTZ];
  assign rup = ra[RA_RUP];
  assign rdn = ra[RA_RDN];
  assign rna = ra[RA_RNA];
  assign rne = !(rtz || rup || rdn || rna);

  logic            swap, xs, ys, y_st, g, st, lsb, inexact, up, hidden, ovf, to_inf;
  logic [NEXP-1:0] xe, ye, d;
  logic [NSIG-1:0] xf, yf, frac;
  logic [NSIG:0]   xm, ym;
  logic [W-1:0]    x_al, y_al, y_ext, n;
  logic [W:0]      s;
  logic [EW-1:0]   e;
  logic [MW-1:0]   mant;
  int              lz, sh;

  always_comb begin
    sum = '0;
    exc = '0;

    // Order operands so x has the larger magnitude; subtraction then never goes negative
    swap = a[NEXP+NSIG-1:0] < b[NEXP+NSIG-1:0];
    xs   = swap ? sb : sa;
    ys   = swap ? sa : sb;
    xe   = swap ? eb : ea;
    ye   = swap ? ea : eb;
    xf   = swap ? fb : fa;
    yf   = swap ? fa : fb;
    xm   = {xe != '0, xf};
    ym   = {ye != '0, yf};
    d    = ((xe == '0) ? NEXP'(1) : xe) - ((ye == '0) ? NEXP'(1) : ye);

    y_ext = {ym, 3'b000};
    if (int'(d) >= W) begin
      y_al = '0;
      y_st = |ym;
    end else begin
      y_al = y_ext >> d;
      y_st = |(y_ext & ~({W{1'b1}} << d));
    end
    y_al[0] = y_al[0] | y_st;
    x_al    = {xm, 3'b000};

    s = (xs == ys) ? ({1'b0, x_al} + {1'b0, y_al}) : ({1'b0, x_al} - {1'b0, y_al});
    e = EW'((xe == '0) ? NEXP'(1) : xe);

    lz = W;
    for (int i = 0; i < W; i++) begin
      if (s[i]) lz = W - 1 - i;
    end

    // Left shift stops at the minimum exponent so tiny results land as subnormals
    if (s[W]) begin
      sh = 0;
      n  = {s[W:2], s[1] | s[0]};
      e  = e + EW'(1);
    end else begin
      sh = (lz < int'(e) - 1) ? lz : int'(e) - 1;
      n  = s[W-1:0] << sh;
      e  = e - EW'(sh);
    end

    lsb     = n[3];
    g       = n[2];
    st      = n[1] | n[0];
    inexact = g | st;
    up      = (rne & g & (st | lsb)) | (rup & ~xs & inexact) |
              (rdn & xs & inexact) | (rna & g);

    mant = {1'b0, n[W-1:3]} + MW'(up);
    if (mant[MW-1]) begin
      e      = e + EW'(1);
      frac   = mant[NSIG:1];
      hidden = 1'b1;
    end else begin
      frac   = mant[NSIG-1:0];
      hidden = mant[NSIG];
    end

    ovf    = e >= {2'b00, EMAX};
    to_inf = ~rtz & ~(rup & xs) & ~(rdn & ~xs);

    if (ovf) begin
      sum = to_inf ? {xs, EMAX, {NSIG{1'b0}}} : {xs, EBIG, {NSIG{1'b1}}};
      exc[EXC_OVERFLOW] = 1'b1;
      exc[EXC_INEXACT]  = 1'b1;
    end else begin
      sum = {xs, (hidden ? e[NEXP-1:0] : {NEXP{1'b0}}), frac};
      exc[EXC_INEXACT]   = inexact;
      exc[EXC_UNDERFLOW] = inexact & ~n[W-1];
    end

    // Exact zero: opposite-signed cancellation is -0 only when rounding down
    if (s == '0) begin
      sum = {((xs == ys) ? xs : rdn), {(NEXP+NSIG){1'b0}}};
      exc = '0;
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      sum = {1'b0, EMAX, 1'b1, {(NSIG-1){1'b0}}};
      exc = '0;
      exc[EXC_INVALID] = snan_a | snan_b | (inf_a & inf_b & (sa != sb));
    end else if (inf_a) begin
      sum = a;
      exc = '0;
    end else if (inf_b) begin
      sum = b;
      exc = '0;
    end
  end

endmodule

// File: rtl/fp_acc_seq.sv
// Sequence accumulator: sums a last-terminated stream of IEEE-754 terms through fp_add.
// Optional FP_ACC_ABORT_EN adds an abort input that discards the current sequence.
module fp_acc_seq
  import fp_acc_seq_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int CNTW = 8
) (
  input logic clk,
  input logic rst,
`ifdef FP_ACC_ABORT_EN
  input logic abort,
`endif
  fp_acc_seq_if.slave bus
);

  localparam int DW = NEXP + NSIG + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [DW-1:0]          acc_reg, acc_next;
  logic [NTYPES-1:0]      flags_reg, flags_next;
  logic [NEXCEPTIONS-1:0] exc_reg, exc_next;
  logic [CNTW-1:0]        count_reg, count_next;
  logic [NRAS:0]          ra_reg, ra_next;

  logic                   in_ready, xfer;
  logic [DW-1:0]          add_a, add_sum;
  logic [NRAS:0]          add_ra;
  logic [NEXCEPTIONS-1:0] add_exc;

  function automatic logic [NTYPES-1:0] classify(input logic [DW-1:0] v);
    logic [NTYPES-1:0] c;
    logic [NEXP-1:0]   ex;
    logic [NSIG-1:0]   fr;
    c  = '0;
    ex = v[DW-2:NSIG];
    fr = v[NSIG-1:0];
    if (ex == '1) begin
      if (fr == '0)         c[FLAG_INFINITY] = 1'b1;
      else if (fr[NSIG-1])  c[FLAG_QNAN]     = 1'b1;
      else                  c[FLAG_SNAN]     = 1'b1;
    end else if (ex == '0) begin
      if (fr == '0) c[FLAG_ZERO]      = 1'b1;
      else          c[FLAG_SUBNORMAL] = 1'b1;
    end else begin
      c[FLAG_NORMAL] = 1'b1;
    end
    return c;
  endfunction

  // The first term of a sequence sees +0 and the live attribute, later terms the latched one
  assign add_a  = (state_reg == IDLE) ? '0 : acc_reg;
  assign add_ra = (state_reg == IDLE) ? bus.ra : ra_reg;

  fp_add #(
    .NEXP (NEXP),
    .NSIG (NSIG)
  ) u_add (
    .a   (add_a),
    .b   (bus.in_data),
    .ra  (add_ra),
    .sum (add_sum),
    .exc (add_exc)
  );

  assign in_ready          = (state_reg != HOLD);
  assign xfer              = bus.in_valid & in_ready;
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_reg == HOLD);
  assign bus.out_sum       = acc_reg;
  assign bus.out_flags     = flags_reg;
  assign bus.out_exception = exc_reg;
  assign bus.out_count     = count_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    flags_next = flags_reg;
    exc_next   = exc_reg;
    count_next = count_reg;
    ra_next    = ra_reg;

    case (state_reg)
      IDLE: begin
        if (xfer) begin
          acc_next   = add_sum;
          flags_next = classify(add_sum);
          exc_next   = add_exc;
          count_next = CNTW'(1);
          ra_next    = bus.ra;
          state_next = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_next   = add_sum;
          flags_next = classify(add_sum);
          exc_next   = exc_reg | add_exc;
          count_next = (count_reg == '1) ? count_reg : count_reg + CNTW'(1);
          state_next = bus.in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

`ifdef FP_ACC_ABORT_EN
    // Abort overrides any transfer or result handshake in the same cycle
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      acc_next   = '0;
      flags_next = '0;
      exc_next   = '0;
      count_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      flags_reg <= '0;
      exc_reg   <= '0;
      count_reg <= '0;
      ra_reg    <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      flags_reg <= flags_next;
      exc_reg   <= exc_next;
      count_reg <= count_next;
      ra_reg    <= ra_next;
    end
  end

endmodule

// File: tb/tb_fp_acc_seq.sv
// Directed, table-driven bench for fp_acc_seq (half precision, 8-bit count),
// with hand-written sequences for stall, saturation, reset and (FP_ACC_ABORT_EN) abort.
module tb_fp_acc_seq;
  import fp_acc_seq_pkg::*;

  logic clk;
  logic rst;
`ifdef FP_ACC_ABORT_EN
  logic abort;
`endif

  fp_acc_seq_if #(.NEXP(5), .NSIG(10), .CNTW(8)) bus ();

  fp_acc_seq #(
    .NEXP (5),
    .NSIG (10),
    .CNTW (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef FP_ACC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       ra;
    logic [2:0]       n;
    logic [3:0][15:0] t;
    logic [15:0]      sum;
    logic [5:0]       flags;
    logic [4:0]       exc;
    logic [7:0]       cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic logic [5:0] fl(input int idx);
    logic [5:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] ex(input int idx);
    logic [4:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input logic [4:0] ra, input logic [2:0] n,
                              input logic [15:0] t0, t1, t2, t3,
                              input logic [15:0] sum, input logic [5:0] flags,
                              input logic [4:0] exc, input logic [7:0] cnt);
    vec_t v;
    v.ra = ra; v.n = n;
    v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
    v.sum = sum; v.flags = flags; v.exc = exc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic last, input logic [4:0] r);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.ra       = r;
    @(negedge clk);
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [15:0] sum, input logic [5:0] flags,
                            input logic [4:0] exc, input logic [7:0] cnt);
    int guard;
    guard         = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_sum"},   32'(bus.out_sum), 32'(sum));
    chk({name, "_flags"}, 32'(bus.out_flags), 32'(flags));
    chk({name, "_exc"},   32'(bus.out_exception), 32'(exc));
    chk({name, "_count"}, 32'(bus.out_count), 32'(cnt));
    $display("%s: sum=%h flags=%b exc=%b count=%0d", name, bus.out_sum, bus.out_flags,
             bus.out_exception, bus.out_count);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];
  logic [4:0] RNE, RTZ, RUP, RDN;
  logic [5:0] NORM, INF, ZERO, SUBN, QNAN;
  logic [4:0] OVX, INX, INV;
  int seen;

  initial begin
    RNE  = ra_sel(RA_RNE);  RTZ = ra_sel(RA_RTZ);
    RUP  = ra_sel(RA_RUP);  RDN = ra_sel(RA_RDN);
    NORM = fl(FLAG_NORMAL); INF = fl(FLAG_INFINITY); ZERO = fl(FLAG_ZERO);
    SUBN = fl(FLAG_SUBNORMAL); QNAN = fl(FLAG_QNAN);
    OVX  = ex(EXC_OVERFLOW) | ex(EXC_INEXACT);
    INX  = ex(EXC_INEXACT);
    INV  = ex(EXC_INVALID);

    vecs[0]  = mk(RNE, 3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0, 16'h4200, NORM, 5'h0, 8'd3);
    vecs[1]  = mk(RNE, 2, 16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 16'h7C00, INF, OVX, 8'd2);
    vecs[2]  = mk(RTZ, 2, 16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 16'h7BFF, NORM, OVX, 8'd2);
    vecs[3]  = mk(RNE, 2, 16'h4000, 16'hC000, 16'h0, 16'h0, 16'h0000, ZERO, 5'h0, 8'd2);
    vecs[4]  = mk(RNE, 1, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h3C00, NORM, 5'h0, 8'd1);
    vecs[5]  = mk(RNE, 2, 16'h7C00, 16'h3C00, 16'h0, 16'h0, 16'h7C00, INF, 5'h0, 8'd2);
    vecs[6]  = mk(RNE, 3, 16'h7C00, 16'hFC00, 16'h3C00, 16'h0, 16'h7E00, QNAN, INV, 8'd3);
    vecs[7]  = mk(RNE, 2, 16'h3C00, 16'h1000, 16'h0, 16'h0, 16'h3C00, NORM, INX, 8'd2);
    vecs[8]  = mk(RUP, 2, 16'h3C00, 16'h1000, 16'h0, 16'h0, 16'h3C01, NORM, INX, 8'd2);
    vecs[9]  = mk(RNE, 2, 16'h0001, 16'h0001, 16'h0, 16'h0, 16'h0002, SUBN, 5'h0, 8'd2);
    vecs[10] = mk(RDN, 2, 16'h4000, 16'hC000, 16'h0, 16'h0, 16'h8000, ZERO, 5'h0, 8'd2);
    vecs[11] = mk(RNE, 4, 16'hBC00, 16'hBC00, 16'h7D00, 16'h3C00, 16'h7E00, QNAN, INV, 8'd4);

    rst = 1'b1;
`ifdef FP_ACC_ABORT_EN
    abort = 1'b0;
`endif
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.ra = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.out_sum), 32'd0);
    chk("rst_flags",     32'(bus.out_flags), 32'd0);
    chk("rst_exc",       32'(bus.out_exception), 32'd0);
    chk("rst_count",     32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++)
        push(vecs[i].t[k], (k == int'(vecs[i].n) - 1), vecs[i].ra);
      get_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].flags, vecs[i].exc, vecs[i].cnt);
    end

    // Attribute is latched on the first term; a later change must not matter
    push(16'h3C00, 1'b0, RUP);
    push(16'h1000, 1'b1, RNE);
    get_result("ra_latch", 16'h3C01, NORM, INX, 8'd2);

    // Stall in HOLD with a competing term offered
    push(16'h3C00, 1'b1, RNE);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h4000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_sum",      32'(bus.out_sum), 32'h3C00);
      chk("hold_count",    32'(bus.out_count), 32'd1);
    end
    $display("hold: sum=%h count=%0d after 3 stalled cycles", bus.out_sum, bus.out_count);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_release_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Count saturates at 255 while the sum keeps growing (260 ones = 0x5C10)
    for (int k = 0; k < 259; k++) push(16'h3C00, 1'b0, RNE);
    push(16'h3C00, 1'b1, RNE);
    get_result("saturate", 16'h5C10, NORM, 5'h0, 8'd255);

    // Reset mid-sequence abandons it silently
    push(16'h3C00, 1'b0, RNE);
    push(16'h3C00, 1'b0, RNE);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    $display("midrst: out_valid cycles after reset=%0d", seen);
    @(posedge clk);
    #1;
    push(16'h3C00, 1'b1, RNE);
    get_result("after_rst", 16'h3C00, NORM, 5'h0, 8'd1);

`ifdef FP_ACC_ABORT_EN
    push(16'h3C00, 1'b0, RNE);
    push(16'h3C00, 1'b0, RNE);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4000;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_count", 32'(bus.out_count), 32'd0);
    chk("abort_sum",   32'(bus.out_sum), 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    $display("abort: out_valid cycles after abort=%0d", seen);
    @(posedge clk);
    #1;
    push(16'h4000, 1'b1, RNE);
    get_result("after_abort", 16'h4000, NORM, 5'h0, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_acc_seq.md
FP_ACC_SEQ -- requirements
Module: fp_acc_seq

Interface
REQ-001 SHALL have parameter NEXP, default 5, exponent width.
REQ-002 SHALL have parameter NSIG, default 10, stored significand width.
REQ-003 SHALL have parameter CNTW, default 8, term-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1, the term handshake.
REQ-007 SHALL have port in_data  input  NEXP+NSIG+1  IEEE-754 term.
REQ-008 SHALL have port in_last  input  1  marks final term of a sequence.
REQ-009 SHALL have port ra  input  NRAS+1  one-hot rounding attribute.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1, the result handshake.
REQ-011 SHALL have port out_sum  output  NEXP+NSIG+1  accumulated sum.
REQ-012 SHALL have port out_flags  output  NTYPES  class flags of out_sum.
REQ-013 SHALL have port out_exception  output  NEXCEPTIONS  sticky OR of per-step exceptions.
REQ-014 SHALL have port out_count  output  CNTW  terms accepted, saturating at 2^CNTW-1.

Function
REQ-015 SHALL drive the fp_add operands as a=acc register, b=in_data, ra=latched mode; adder is combinational.
REQ-016 SHALL implement states IDLE, ACCUM, HOLD; in_ready=1 in IDLE/ACCUM, 0 in HOLD.
REQ-017 SHALL treat a transfer as in_valid&in_ready at a rising edge; one term per cycle, no bubbles.
REQ-018 SHALL, on a transfer in IDLE, use +0 as acc operand, latch ra, and load acc, flags, exceptions, count=1.
REQ-019 SHALL, on a transfer in ACCUM, load acc with adder sum, OR adder exception into sticky, increment count.
REQ-020 SHALL move to ACCUM after a non-last transfer and to HOLD after a last transfer (IDLE or ACCUM).
REQ-021 SHALL assert out_valid only in HOLD, registered: first cycle after the last transfer.
REQ-022 SHALL hold out_sum/flags/exception/count stable while out_valid&~out_ready.
REQ-023 SHALL return to IDLE on out_valid&out_ready; next term accepted one cycle later.
REQ-024 SHALL ignore ra changes after the first term of a sequence.
REQ-025 SHALL saturate out_count at all-ones without wrap; sum continues to accumulate.
REQ-026 SHALL keep accumulating after a NaN or infinity; propagation is the adder's.

Reset
REQ-027 SHALL on rst: state IDLE, acc=0, out_valid=0, in_ready=1 after release, flags=0, exception=0, count=0, latched ra=0.
REQ-028 SHALL abandon any in-progress or held sequence on rst without emitting a result.

Configuration
REQ-029 SHALL, with FP_ACC_ABORT_EN defined, add port abort input 1; abort in ACCUM or HOLD returns to IDLE next edge, clears acc/sticky/count, emits nothing; a simultaneous transfer is dropped.
REQ-030 SHALL, without FP_ACC_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-031 SHALL take NTYPES, NEXCEPTIONS, NRAS, flag and exception bit indices, rounding-attribute indices from the shared IEEE-754 package; state enum local.
REQ-032 SHALL instantiate exactly one sub-module, the existing fp_add, parameterised by NEXP/NSIG.

Verification
REQ-033 SHALL cover: terms 0x3C00,0x3C00,0x3C00(last), RNE -> out_sum 0x4200, NORMAL set, exception 0, count 3.
REQ-034 SHALL cover: 0x7BFF,0x7BFF(last), RNE -> 0x7C00, INFINITY, OVERFLOW|INEXACT; RTZ -> 0x7BFF, NORMAL.
REQ-035 SHALL cover: out_ready low 3 cycles in HOLD -> outputs stable, in_ready 0; handshake then IDLE.
REQ-036 SHALL cover: 0x4000 then 0xC000(last) -> out_sum zero, ZERO flag set, count 2.
REQ-037 SHALL cover: rst asserted after 2 of 4 terms -> out_valid never rises; next sequence 0x3C00(last) -> 0x3C00, count 1.
REQ-038 SHALL cover, with FP_ACC_ABORT_EN: abort after 2 terms -> IDLE, no output; following sequence sums from +0.
